// File: rtl/i2c_bus_conditioner.sv
// i2c_bus_conditioner: SCL/SDA synchroniser, glitch filter and
// START/STOP detector feeding the I2C slave FSM.
module i2c_bus_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int STOP_PULSE  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_f,
    output logic sda_f,
    output logic start_o,
    output logic stop_o,
    output logic bus_busy
);
    localparam int SETTLE = SYNC_STAGES + FILT_LEN;
    localparam int SW     = $clog2(SETTLE + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    pin;
    logic [1:0]    filt;
    logic          scl_d;
    logic          sda_d;
    logic [SW-1:0] settle_q;
    logic [3:0]    stop_cnt_q;
    logic          settled;
    logic          start_det;
    logic          stop_det;
    logic          scl_rise;
    logic          start_set;
    logic          start_clr;
    logic          stop_fire;

    assign pin = {sda_i, scl_i};

    // Line 0 is SCL, line 1 is SDA.
    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] sync_q;
        logic [3:0]             cnt_q;
        logic                   filt_q;
        logic                   smp;

        assign smp     = sync_q[SYNC_STAGES-1];
        assign filt[i] = filt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '1;
                cnt_q  <= '0;
                filt_q <= 1'b1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pin[i]};
                if (smp == filt_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == 4'(FILT_LEN - 1)) begin
                    filt_q <= ~filt_q;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

    assign scl_f = filt[0];
    assign sda_f = filt[1];

    // Conditions are ignored until the pipeline holds real pin data.
    assign settled   = (settle_q == '0);
    assign scl_rise  = ~scl_d & scl_f;
    assign start_det = settled & sda_d & ~sda_f & scl_d & scl_f;
    assign stop_det  = settled & ~sda_d & sda_f & scl_d & scl_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_det) state_d = ACTIVE;
            ACTIVE:  if (stop_det)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_set = start_det;
        stop_fire = (state_q == ACTIVE) & stop_det;
        start_clr = stop_fire | (start_o & scl_rise);
    end

    assign bus_busy = (state_q == ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q   <= SW'(SETTLE);
            scl_d      <= 1'b1;
            sda_d      <= 1'b1;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            stop_cnt_q <= '0;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
            if (!settled) begin
                settle_q <= settle_q - SW'(1);
            end
            if (start_set) begin
                start_o <= 1'b1;
            end else if (start_clr) begin
                start_o <= 1'b0;
            end
            if (stop_fire) begin
                stop_o     <= 1'b1;
                stop_cnt_q <= 4'(STOP_PULSE - 1);
            end else if (stop_cnt_q != 4'd0) begin
                stop_cnt_q <= stop_cnt_q - 4'd1;
            end else begin
                stop_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner: fixed vectors, corner sequences
// and random pin activity against a behavioural model.
module tb_i2c_bus_conditioner;
    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int SP   = 2;
    localparam int L    = SYNC + FILT;

    logic clk = 1'b0;
    logic rst_n;
    logic scl_i;
    logic sda_i;
    logic scl_f;
    logic sda_f;
    logic start_o;
    logic stop_o;
    logic bus_busy;

    int checks = 0;
    int errors = 0;

    i2c_bus_conditioner #(
        .SYNC_STAGES(SYNC),
        .FILT_LEN   (FILT),
        .STOP_PULSE (SP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .scl_f   (scl_f),
        .sda_f   (sda_f),
        .start_o (start_o),
        .stop_o  (stop_o),
        .bus_busy(bus_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: pin history window plus bus flags.
    bit q_scl[$];
    bit q_sda[$];
    bit m_scl_f, m_sda_f, m_scl_d, m_sda_d;
    bit m_active, m_start;
    int m_settle;
    int m_stop_left;

    task automatic model_reset();
        q_scl.delete();
        q_sda.delete();
        for (int i = 0; i < L; i++) begin
            q_scl.push_back(1'b1);
            q_sda.push_back(1'b1);
        end
        m_scl_f = 1; m_sda_f = 1; m_scl_d = 1; m_sda_d = 1;
        m_active = 0; m_start = 0;
        m_settle = L;
        m_stop_left = 0;
    endtask

    // True when the oldest FILT samples (ending SYNC edges ago) all equal v.
    function automatic bit win_all(input bit q[$], input bit v);
        for (int j = 0; j < FILT; j++)
            if (q[j] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit st, sp, rise, nscl, nsda;
        st   = (m_settle == 0) && m_sda_d && !m_sda_f && m_scl_d && m_scl_f;
        sp   = (m_settle == 0) && !m_sda_d && m_sda_f && m_scl_d && m_scl_f;
        rise = !m_scl_d && m_scl_f;
        if (m_stop_left > 0) m_stop_left--;
        if (st) begin
            m_active = 1; m_start = 1;
        end else if (sp && m_active) begin
            m_active = 0; m_start = 0; m_stop_left = SP;
        end else if (rise) begin
            m_start = 0;
        end
        q_scl.push_back(scl_i); void'(q_scl.pop_front());
        q_sda.push_back(sda_i); void'(q_sda.pop_front());
        nscl = win_all(q_scl, !m_scl_f) ? !m_scl_f : m_scl_f;
        nsda = win_all(q_sda, !m_sda_f) ? !m_sda_f : m_sda_f;
        m_scl_d = m_scl_f; m_sda_d = m_sda_f;
        m_scl_f = nscl; m_sda_f = nsda;
        if (m_settle > 0) m_settle--;
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string nm, input logic e_scl, input logic e_sda,
                              input logic e_st, input logic e_sp, input logic e_busy);
        check1({nm, "_scl_f"}, scl_f, e_scl);
        check1({nm, "_sda_f"}, sda_f, e_sda);
        check1({nm, "_start"}, start_o, e_st);
        check1({nm, "_stop"}, stop_o, e_sp);
        check1({nm, "_busy"}, bus_busy, e_busy);
    endtask

    task automatic step_clk();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outs("mdl", m_scl_f, m_sda_f, m_start, m_stop_left > 0, m_active);
    endtask

    task automatic hold(input logic c, input logic d, input int n);
        scl_i = c;
        sda_i = d;
        repeat (n) step_clk();
    endtask

    typedef struct {
        logic scl;
        logic sda;
        int   n;
        logic e_scl;
        logic e_sda;
        logic e_st;
        logic e_sp;
        logic e_busy;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        tbl[0]  = '{1, 1, 10, 1, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 6,  1, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1,  1, 0, 1, 0, 1};
        tbl[3]  = '{0, 0, 8,  0, 0, 1, 0, 1};
        tbl[4]  = '{1, 0, 6,  1, 0, 1, 0, 1};
        tbl[5]  = '{1, 0, 1,  1, 0, 0, 0, 1};
        tbl[6]  = '{0, 0, 8,  0, 0, 0, 0, 1};
        tbl[7]  = '{0, 1, 8,  0, 1, 0, 0, 1};
        tbl[8]  = '{1, 1, 8,  1, 1, 0, 0, 1};
        tbl[9]  = '{1, 0, 7,  1, 0, 1, 0, 1};
        tbl[10] = '{1, 1, 6,  1, 1, 1, 0, 1};
        tbl[11] = '{1, 1, 1,  1, 1, 0, 1, 0};
        tbl[12] = '{1, 1, 1,  1, 1, 0, 1, 0};
        tbl[13] = '{1, 1, 1,  1, 1, 0, 0, 0};
        tbl[14] = '{1, 0, 3,  1, 1, 0, 0, 0};
        tbl[15] = '{1, 1, 10, 1, 1, 0, 0, 0};
        tbl[16] = '{1, 0, 4,  1, 1, 0, 0, 0};
        tbl[17] = '{1, 1, 3,  1, 0, 1, 0, 1};
        tbl[18] = '{1, 1, 3,  1, 1, 1, 0, 1};
        tbl[19] = '{1, 1, 1,  1, 1, 0, 1, 0};
        tbl[20] = '{1, 1, 5,  1, 1, 0, 0, 0};
        tbl[21] = '{0, 0, 8,  0, 0, 0, 0, 0};
        tbl[22] = '{1, 1, 8,  1, 1, 0, 0, 0};

        rst_n = 1'b0;
        scl_i = 1'b1;
        sda_i = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_outs("reset", 1, 1, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            hold(tbl[i].scl, tbl[i].sda, tbl[i].n);
            check_outs($sformatf("vec%0d", i), tbl[i].e_scl, tbl[i].e_sda,
                       tbl[i].e_st, tbl[i].e_sp, tbl[i].e_busy);
        end

        // Reset in the middle of a byte with both lines low.
        hold(1, 0, 7);
        check_outs("t6_pre", 1, 0, 1, 0, 1);
        hold(0, 0, 8);
        #2 rst_n = 1'b0;
        #1 check_outs("t6_async", 1, 1, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold(0, 0, 6);
        check_outs("t6_track", 0, 0, 0, 0, 0);
        hold(1, 0, 8);
        check_outs("t6_scl_up", 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            hold(1, 1, 1);
            check1("t6_idle_stop", stop_o, 1'b0);
        end
        hold(1, 0, 7);
        check_outs("t6_start", 1, 0, 1, 0, 1);

        for (int s = 0; s < 300; s++) begin
            hold(1'($urandom), 1'($urandom), int'($urandom_range(1, 10)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
